// File: rtl/counting_pkg.sv
// rtl/counting_pkg.sv - shared symbol constants and state encoding for the num symbol stream
package counting_pkg;

    localparam logic [1:0] SYM_IDLE = 2'b00;
    localparam logic [1:0] SYM_HEAD = 2'b01;
    localparam logic [1:0] SYM_MID  = 2'b10;
    localparam logic [1:0] SYM_TAIL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAD = 2'b01,
        ST_MID  = 2'b10,
        ST_TAIL = 2'b11
    } state_t;

endpackage

// File: rtl/counting_down_cnt.sv
// rtl/counting_down_cnt.sv - W-bit loadable down-counter with zero flag
module counting_down_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/counting_gen.sv
// rtl/counting_gen.sv - frame generator: 01, N2 x 10, N3 x 11, then 00; optional COUNTING_GEN_STALL_EN adds ready backpressure
module counting_gen
    import counting_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] len2,
    input  logic [W-1:0] len3,
`ifdef COUNTING_GEN_STALL_EN
    input  logic         ready,
`endif
    output logic [1:0]   num,
    output logic         valid,
    output logic         busy,
    output logic         done
);

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] len2_q;
    logic [W-1:0] len3_q;
    logic         done_q;
    logic         done_d;
    logic         advance;
    logic         cnt_load;
    logic         cnt_en;
    logic [W-1:0] cnt_load_val;
    logic         cnt_zero;

`ifdef COUNTING_GEN_STALL_EN
    assign advance = ready;
`else
    assign advance = 1'b1;
`endif

    // A run of length 0 is clamped to 1, so the reload value is max(len,1)-1.
    function automatic logic [W-1:0] run_load(input logic [W-1:0] len);
        return (len == '0) ? '0 : (len - W'(1));
    endfunction

    counting_down_cnt #(
        .W (W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len2_q  <= '0;
            len3_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (state_q == ST_IDLE && start) begin
                len2_q <= len2;
                len3_q <= len3;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_load_val = '0;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (advance) begin
                    state_d      = ST_MID;
                    cnt_load     = 1'b1;
                    cnt_load_val = run_load(len2_q);
                end
            end
            ST_MID: begin
                if (advance) begin
                    if (cnt_zero) begin
                        state_d      = ST_TAIL;
                        cnt_load     = 1'b1;
                        cnt_load_val = run_load(len3_q);
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_TAIL: begin
                if (advance) begin
                    if (cnt_zero) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        num   = SYM_IDLE;
        valid = 1'b0;
        busy  = 1'b0;
        done  = done_q;
        case (state_q)
            ST_HEAD: num = SYM_HEAD;
            ST_MID:  num = SYM_MID;
            ST_TAIL: num = SYM_TAIL;
            default: num = SYM_IDLE;
        endcase
        if (state_q != ST_IDLE) begin
            valid = 1'b1;
            busy  = 1'b1;
        end
    end

endmodule
